// File: rtl/mrfm_cic_decim_pkg.sv
// mrfm_cic_decim_pkg
// Shared constants and types for the MRFM CIC decimator.
//   FR_MRFM_DECIM_RATE / FR_MRFM_DECIM_SHIFT : setting-bus addresses of the
//     rate and shift registers. They sit in the FR_MRFM_* address map.
//   cic_cfg_t   : the programmed rate (R-1) and output shift.
//   clamp_shift : limits a written shift value to the accumulator width.
package mrfm_cic_decim_pkg;

  localparam logic [6:0] FR_MRFM_DECIM_RATE  = 7'd72;
  localparam logic [6:0] FR_MRFM_DECIM_SHIFT = 7'd73;
  localparam int         MAX_SHIFT           = 48;

  typedef struct packed {
    logic [7:0] rate;   // R-1
    logic [5:0] shift;  // 0..MAX_SHIFT
  } cic_cfg_t;

  // Shifting by more than the accumulator width has no meaning, so pin it.
  function automatic logic [5:0] clamp_shift(input logic [5:0] s);
    return (s > 6'(MAX_SHIFT)) ? 6'(MAX_SHIFT) : s;
  endfunction

endpackage

// File: rtl/mrfm_cic_decim_if.sv
// mrfm_cic_decim_if
// Groups the setting bus and the sample streams of the CIC decimator.
//   serial_strobe/addr/data : setting-bus write
//   strobe_in/sample_in     : full-rate input samples
//   strobe_out/sample_out   : decimated output, feeds the biquad IIR
// master: the driving side (bus master / upstream source and downstream sink)
// slave : the decimator
interface mrfm_cic_decim_if;
  logic        serial_strobe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        strobe_in;
  logic [15:0] sample_in;
  logic        strobe_out;
  logic [15:0] sample_out;

  modport master (
    output serial_strobe, serial_addr, serial_data, strobe_in, sample_in,
    input  strobe_out, sample_out
  );

  modport slave (
    input  serial_strobe, serial_addr, serial_data, strobe_in, sample_in,
    output strobe_out, sample_out
  );
endinterface

// File: rtl/mrfm_cic_decim_comb_stage.sv
// mrfm_cic_decim_comb_stage
// One CIC comb stage: y = x - x_delayed, with the delay register advanced
// only on valid input. Output valid is the input valid delayed one clock.
// Ports:
//   clock  : system clock
//   i_clr  : synchronous clear of data, delay and valid (reset or rate change)
//   i_vld  : input valid
//   i_x    : input value
//   o_vld  : output valid
//   o_y    : comb output
module mrfm_cic_decim_comb_stage #(
  parameter int W = 48
) (
  input  logic                clock,
  input  logic                i_clr,
  input  logic                i_vld,
  input  logic signed [W-1:0] i_x,
  output logic                o_vld,
  output logic signed [W-1:0] o_y
);

  logic                r_vld;
  logic signed [W-1:0] r_y;
  logic signed [W-1:0] r_dly;

  always_ff @(posedge clock) begin
    if (i_clr) begin
      r_vld <= 1'b0;
      r_y   <= '0;
      r_dly <= '0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_y   <= i_x - r_dly;
        r_dly <= i_x;
      end
    end
  end

  assign o_vld = r_vld;
  assign o_y   = r_y;

endmodule

// File: rtl/mrfm_cic_decim.sv
// mrfm_cic_decim
// Programmable 4-stage CIC decimator (R = 1..256) with rounding right
// shift for gain normalisation. Upstream of the MRFM biquad IIR.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : mrfm_cic_decim_if.slave (setting bus, strobe_in/sample_in,
//           strobe_out/sample_out)
// Build option:
//   MRFM_DECIM_SAT_EN : saturate the output to 16 bits and keep a sticky
//                       overflow flag (r_ovf). Otherwise the output wraps.
// Timing: strobe_out rises 6 clocks after the edge that samples the
// decimating strobe_in (1 capture + 4 comb stages + output register).
module mrfm_cic_decim
  import mrfm_cic_decim_pkg::*;
#(
  parameter int         N_STAGES   = 4,
  parameter int         ACC_WIDTH  = 48,
  parameter logic [6:0] RATE_ADDR  = FR_MRFM_DECIM_RATE,
  parameter logic [6:0] SHIFT_ADDR = FR_MRFM_DECIM_SHIFT
) (
  input  logic               clock,
  input  logic               reset,
  mrfm_cic_decim_if.slave    bus
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = 32767;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -32768;

  // ---------------------------------------------------------------- settings
  cic_cfg_t r_cfg;
  logic     w_rate_wr;
  logic     w_shift_wr;
  logic     w_clr;
  logic     w_unused;

  assign w_rate_wr  = bus.serial_strobe && (bus.serial_addr == RATE_ADDR);
  assign w_shift_wr = bus.serial_strobe && (bus.serial_addr == SHIFT_ADDR);
  // A rate change restarts the filter from zero so old and new rates never mix.
  assign w_clr      = reset || w_rate_wr;
  assign w_unused   = &{1'b0, bus.serial_data[31:8]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cfg <= '0;
    end else begin
      if (w_rate_wr)  r_cfg.rate  <= bus.serial_data[7:0];
      if (w_shift_wr) r_cfg.shift <= clamp_shift(bus.serial_data[5:0]);
    end
  end

  // ------------------------------------------------------------ integrators
  logic signed [ACC_WIDTH-1:0] r_integ [N_STAGES];
  logic signed [ACC_WIDTH-1:0] w_x_ext;

  assign w_x_ext = {{(ACC_WIDTH-16){bus.sample_in[15]}}, bus.sample_in};

  // Modulo-2^ACC_WIDTH wrap is intentional: the combs undo it exactly.
  always_ff @(posedge clock) begin
    if (w_clr) begin
      for (int k = 0; k < N_STAGES; k++) r_integ[k] <= '0;
    end else if (bus.strobe_in) begin
      r_integ[0] <= r_integ[0] + w_x_ext;
      for (int k = 1; k < N_STAGES; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
    end
  end

  // ---------------------------------------------------- decimation counter
  logic [7:0] r_cnt;
  logic       w_dec;

  assign w_dec = bus.strobe_in && (r_cnt == r_cfg.rate);

  always_ff @(posedge clock) begin
    if (w_clr)              r_cnt <= '0;
    else if (bus.strobe_in) r_cnt <= w_dec ? 8'd0 : r_cnt + 8'd1;
  end

  // ------------------------------------------- capture + comb pipeline
  // vld_pipe[0]: decimating strobe seen; vld_pipe[1]: integrator captured.
  logic [1:0]                  r_vld_pipe;
  logic signed [ACC_WIDTH-1:0] r_cap;

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_vld_pipe <= '0;
      r_cap      <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], w_dec};
      if (r_vld_pipe[0]) r_cap <= r_integ[N_STAGES-1];
    end
  end

  logic                        w_comb_vld [N_STAGES+1];
  logic signed [ACC_WIDTH-1:0] w_comb_dat [N_STAGES+1];

  assign w_comb_vld[0] = r_vld_pipe[1];
  assign w_comb_dat[0] = r_cap;

  for (genvar g = 0; g < N_STAGES; g++) begin : g_comb
    mrfm_cic_decim_comb_stage #(.W(ACC_WIDTH)) u_comb (
      .clock (clock),
      .i_clr (w_clr),
      .i_vld (w_comb_vld[g]),
      .i_x   (w_comb_dat[g]),
      .o_vld (w_comb_vld[g+1]),
      .o_y   (w_comb_dat[g+1])
    );
  end

  // ------------------------------------------------------ output formatting
  logic signed [ACC_WIDTH-1:0] w_y;
  logic signed [ACC_WIDTH-1:0] w_shifted;
  logic signed [ACC_WIDTH-1:0] w_scaled;
  logic        [ACC_WIDTH-1:0] w_half_vec;
  logic                        w_rbit;
  logic        [15:0]          w_fmt;

  assign w_y        = w_comb_dat[N_STAGES];
  // Kept as its own signal so the shift stays arithmetic.
  assign w_shifted  = w_y >>> r_cfg.shift;
  // Bit shift-1 of the unshifted value is the half-LSB for round half up.
  // With shift=0 the subtraction wraps to 63, which shifts everything out.
  assign w_half_vec = w_y >> (r_cfg.shift - 6'd1);
  assign w_rbit     = (r_cfg.shift != 6'd0) & w_half_vec[0];
  assign w_scaled   = w_shifted + ACC_WIDTH'(w_rbit);

`ifdef MRFM_DECIM_SAT_EN
  logic w_clip;
  logic r_ovf;

  always_comb begin
    w_fmt  = w_scaled[15:0];
    w_clip = 1'b0;
    if (w_scaled > SAT_MAX) begin
      w_fmt  = 16'h7fff;
      w_clip = 1'b1;
    end else if (w_scaled < SAT_MIN) begin
      w_fmt  = 16'h8000;
      w_clip = 1'b1;
    end
  end
`else
  always_comb begin
    w_fmt = w_scaled[15:0];
  end
`endif

  logic        r_strobe_out;
  logic [15:0] r_sample_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_strobe_out <= 1'b0;
      r_sample_out <= '0;
`ifdef MRFM_DECIM_SAT_EN
      r_ovf        <= 1'b0;
`endif
    end else if (w_rate_wr) begin
      // Anything still in flight belongs to the old rate; drop it.
      r_strobe_out <= 1'b0;
    end else begin
      r_strobe_out <= w_comb_vld[N_STAGES];
      if (w_comb_vld[N_STAGES]) begin
        r_sample_out <= w_fmt;
`ifdef MRFM_DECIM_SAT_EN
        if (w_clip) r_ovf <= 1'b1;
`endif
      end
    end
  end

  assign bus.strobe_out = r_strobe_out;
  assign bus.sample_out = r_sample_out;

endmodule

// File: tb/tb_mrfm_cic_decim.sv
module tb_mrfm_cic_decim;
  import mrfm_cic_decim_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mrfm_cic_decim_if bus ();

  mrfm_cic_decim dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc = 0;
  int  n_pass = 0;
  int  n_total = 0;

  // ---------------------------------------------------------------- model
  // Four cascaded integrators; each integrator k>0 accumulates the value
  // integrator k-1 held before this strobe. Combs run at the decimated rate.
  // Formatting uses exact round-half-up arithmetic on 64-bit integers.
  logic signed [47:0] mi [4];
  logic signed [47:0] mc [4];
  int m_cnt, m_rate, m_shift;

  initial begin
    logic signed [47:0] ni [4];
    logic signed [47:0] v, y;
    longint r;
    for (int k = 0; k < 4; k++) begin mi[k] = 0; mc[k] = 0; end
    m_cnt = 0; m_rate = 0; m_shift = 0;
    forever begin
      @(posedge clock);
      cyc++;
      if (reset || (bus.serial_strobe && bus.serial_addr == FR_MRFM_DECIM_RATE)) begin
        for (int k = 0; k < 4; k++) begin mi[k] = 0; mc[k] = 0; end
        m_cnt = 0;
        if (reset) begin m_rate = 0; m_shift = 0; end
        else m_rate = int'(bus.serial_data[7:0]);
        while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) exp_q.pop_back();
      end else begin
        if (bus.serial_strobe && bus.serial_addr == FR_MRFM_DECIM_SHIFT)
          m_shift = (int'(bus.serial_data[5:0]) > 48) ? 48 : int'(bus.serial_data[5:0]);
        if (bus.strobe_in) begin
          ni[0] = mi[0] + 48'(signed'(bus.sample_in));
          for (int k = 1; k < 4; k++) ni[k] = mi[k] + mi[k-1];
          mi = ni;
          if (m_cnt == m_rate) begin
            m_cnt = 0;
            v = mi[3];
            for (int k = 0; k < 4; k++) begin y = v - mc[k]; mc[k] = v; v = y; end
            r = longint'(v);
            if (m_shift > 0) r = (r + (64'sd1 <<< (m_shift - 1))) >>> m_shift;
`ifdef MRFM_DECIM_SAT_EN
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
`endif
            exp_q.push_back('{cyc + 6, 16'(r)});
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  // Output monitor, away from the active edge.
  initial forever begin
    @(negedge clock);
    if (bus.strobe_out === 1'b1) obs_q.push_back('{cyc, bus.sample_out});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // --------------------------------------------------------------- drivers
  task automatic drv(input logic s, input logic [15:0] x);
    bus.strobe_in = s; bus.sample_in = x;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    bus.strobe_in = 1'b0; bus.sample_in = '0;
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    bus.strobe_in = 1'b0;
    bus.serial_strobe = 1'b1; bus.serial_addr = a; bus.serial_data = d;
    @(negedge clock);
    bus.serial_strobe = 1'b0;
  endtask

  task automatic do_reset();
    bus.strobe_in = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic clr_q();
    exp_q.delete(); obs_q.delete();
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1;
    bus.strobe_in = 1'b1; bus.sample_in = 16'h1234;
    repeat (3) @(negedge clock);
    n_total++;
    if (bus.strobe_out !== 1'b0) $display("FAIL reset_strobe: got %b, expected 0", bus.strobe_out);
    else n_pass++;
    n_total++;
    if (bus.sample_out !== 16'h0) $display("FAIL reset_sample: got %h, expected 0000", bus.sample_out);
    else n_pass++;
    reset = 1'b0;
    clr_q();
    idle(12);
    n_total++;
    if (obs_q.size() != 0) $display("FAIL reset_idle: got %0d outputs, expected 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_const_r4();
    do_reset(); wr(FR_MRFM_DECIM_RATE, 32'd3); wr(FR_MRFM_DECIM_SHIFT, 32'd8); clr_q();
    repeat (48) drv(1'b1, 16'd1000);
    idle(10);
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL r4_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
        $display("FAIL r4_out%0d: got cyc %0d val %0d, expected cyc %0d val %0d", i,
                 obs_q[i].cyc, $signed(obs_q[i].val), exp_q[i].cyc, $signed(exp_q[i].val));
      else n_pass++;
    end
    n_total++;
    if (obs_q.size() < 3) $display("FAIL r4_settled: got %0d outputs, expected at least 3", obs_q.size());
    else if (obs_q[$].val !== 16'd1000 || obs_q[$-1].val !== 16'd1000 || obs_q[$-2].val !== 16'd1000 ||
             obs_q[$].cyc - obs_q[$-1].cyc != 4)
      $display("FAIL r4_settled: got %0d spacing %0d, expected 1000 spacing 4",
               $signed(obs_q[$].val), obs_q[$].cyc - obs_q[$-1].cyc);
    else n_pass++;
  endtask

  task automatic test_impulse();
    int t0, nz;
    logic [15:0] nzv;
    do_reset(); wr(FR_MRFM_DECIM_RATE, 32'd0); wr(FR_MRFM_DECIM_SHIFT, 32'd0); clr_q();
    t0 = cyc + 1;
    drv(1'b1, 16'd1);
    repeat (15) drv(1'b1, 16'd0);
    idle(10);
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL imp_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
        $display("FAIL imp_out%0d: got cyc %0d val %0d, expected cyc %0d val %0d", i,
                 obs_q[i].cyc, $signed(obs_q[i].val), exp_q[i].cyc, $signed(exp_q[i].val));
      else n_pass++;
    end
    n_total++;
    if (obs_q.size() == 0 || obs_q[0].cyc != t0 + 6)
      $display("FAIL imp_latency: got first strobe_out at %0d, expected %0d", obs_q.size() ? obs_q[0].cyc : -1, t0 + 6);
    else n_pass++;
    nz = 0; nzv = '0;
    foreach (obs_q[i]) if (obs_q[i].val != 0) begin nz++; nzv = obs_q[i].val; end
    n_total++;
    if (nz != 1 || nzv !== 16'd1) $display("FAIL imp_unit: got %0d nonzero (last %0d), expected one of value 1", nz, nzv);
    else n_pass++;
  endtask

  task automatic test_r256();
    do_reset(); wr(FR_MRFM_DECIM_RATE, 32'd255); wr(FR_MRFM_DECIM_SHIFT, 32'd32); clr_q();
    repeat (7 * 256) begin drv(1'b1, 16'h8000); drv(1'b0, 16'h0); end
    idle(10);
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL r256_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
        $display("FAIL r256_out%0d: got cyc %0d val %0d, expected cyc %0d val %0d", i,
                 obs_q[i].cyc, $signed(obs_q[i].val), exp_q[i].cyc, $signed(exp_q[i].val));
      else n_pass++;
    end
    n_total++;
    if (obs_q.size() < 2) $display("FAIL r256_settled: got %0d outputs, expected at least 2", obs_q.size());
    else if (obs_q[$].val !== 16'h8000 || obs_q[$-1].val !== 16'h8000 || obs_q[$].cyc - obs_q[$-1].cyc != 512)
      $display("FAIL r256_settled: got %0d spacing %0d, expected -32768 spacing 512",
               $signed(obs_q[$].val), obs_q[$].cyc - obs_q[$-1].cyc);
    else n_pass++;
  endtask

  task automatic test_sat();
    logic [15:0] want;
`ifdef MRFM_DECIM_SAT_EN
    want = 16'h7fff;
`else
    want = 16'h9c40;
`endif
    do_reset(); wr(FR_MRFM_DECIM_RATE, 32'd3); wr(FR_MRFM_DECIM_SHIFT, 32'd7); clr_q();
    repeat (48) drv(1'b1, 16'd20000);
    idle(10);
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL sat_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
        $display("FAIL sat_out%0d: got cyc %0d val %0d, expected cyc %0d val %0d", i,
                 obs_q[i].cyc, $signed(obs_q[i].val), exp_q[i].cyc, $signed(exp_q[i].val));
      else n_pass++;
    end
    n_total++;
    if (bus.sample_out !== want) $display("FAIL sat_final: got %h, expected %h", bus.sample_out, want);
    else n_pass++;
`ifdef MRFM_DECIM_SAT_EN
    n_total++;
    if (dut.r_ovf !== 1'b1) $display("FAIL sat_flag: got %b, expected 1", dut.r_ovf);
    else n_pass++;
`endif
  endtask

  task automatic test_rate_change();
    int tw, first, inwin;
    do_reset(); wr(FR_MRFM_DECIM_RATE, 32'd3); wr(FR_MRFM_DECIM_SHIFT, 32'd8); clr_q();
    repeat (26) drv(1'b1, 16'($urandom));
    // Rate write coincides with a strobe: that sample must be dropped.
    bus.serial_strobe = 1'b1; bus.serial_addr = FR_MRFM_DECIM_RATE; bus.serial_data = 32'd7;
    bus.strobe_in = 1'b1; bus.sample_in = 16'($urandom);
    tw = cyc + 1;
    @(negedge clock);
    bus.serial_strobe = 1'b0;
    repeat (32) drv(1'b1, 16'($urandom));
    idle(10);
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL rchg_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
        $display("FAIL rchg_out%0d: got cyc %0d val %0d, expected cyc %0d val %0d", i,
                 obs_q[i].cyc, $signed(obs_q[i].val), exp_q[i].cyc, $signed(exp_q[i].val));
      else n_pass++;
    end
    first = -1; inwin = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].cyc >= tw && obs_q[i].cyc <= tw + 6) inwin++;
      if (obs_q[i].cyc >= tw && first < 0) first = obs_q[i].cyc;
    end
    n_total++;
    if (inwin != 0) $display("FAIL rchg_quiet: got %0d strobes after write, expected 0", inwin);
    else n_pass++;
    n_total++;
    if (first != tw + 14) $display("FAIL rchg_first: got cycle %0d, expected %0d", first, tw + 14);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ts, late;
    do_reset(); wr(FR_MRFM_DECIM_SHIFT, 32'd0); clr_q();
    repeat (10) drv(1'b1, 16'd5000);
    idle(10);
    n_total++;
    if (obs_q.size() == 0 || obs_q[$].val !== exp_q[$].val || obs_q[$].val !== 16'd5000)
      $display("FAIL rmid_pre: got %0d outputs, last %0d, expected last 5000", obs_q.size(), obs_q.size() ? obs_q[$].val : 0);
    else n_pass++;
    clr_q();
    ts = cyc + 1;
    drv(1'b1, 16'd7);
    idle(2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    idle(12);
    late = 0;
    foreach (obs_q[i]) if (obs_q[i].cyc > ts) late++;
    n_total++;
    if (late != 0 || exp_q.size() != 0) $display("FAIL rmid_none: got %0d strobes (model %0d), expected 0", late, exp_q.size());
    else n_pass++;
    n_total++;
    if (bus.sample_out !== 16'h0) $display("FAIL rmid_sample: got %h, expected 0000", bus.sample_out);
    else n_pass++;
  endtask

  task automatic test_random();
    int dens;
    for (int it = 0; it < 4; it++) begin
      clr_q();
      wr(FR_MRFM_DECIM_RATE, 32'($urandom_range(0, 15)));
      wr(FR_MRFM_DECIM_SHIFT, (it == 3) ? 32'd60 : 32'($urandom_range(0, 20)));
      dens = $urandom_range(40, 100);
      repeat (160) drv(($urandom_range(1, 100) <= dens) ? 1'b1 : 1'b0, 16'($urandom));
      idle(10);
      n_total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL rnd%0d_count: got %0d, expected %0d", it, obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_total++;
        if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val)
          $display("FAIL rnd%0d_out%0d: got cyc %0d val %0d, expected cyc %0d val %0d", it, i,
                   obs_q[i].cyc, $signed(obs_q[i].val), exp_q[i].cyc, $signed(exp_q[i].val));
        else n_pass++;
      end
    end
  endtask

  initial begin
    bus.serial_strobe = 1'b0; bus.serial_addr = '0; bus.serial_data = '0;
    bus.strobe_in = 1'b0; bus.sample_in = '0;
    @(negedge clock);
    test_reset();
    test_const_r4();
    test_impulse();
    test_r256();
    test_sat();
    test_rate_change();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
